// File: rtl/im_boot_loader_pkg.sv
// Shared constants for the instruction-memory boot loader and region-select logic.
package im_boot_loader_pkg;

    localparam int unsigned BYTE_W      = 8;
    localparam int unsigned WORD_W      = 32;
    localparam int unsigned WADDR_W     = 30;
    localparam int unsigned WIDX_W      = 10;
    localparam int unsigned LEN_W       = 11;
    localparam int unsigned DEPTH_WORDS = 1024;

    localparam logic [7:0]  SYNC_BYTE   = 8'hA5;
    localparam logic [7:0]  REGION_CODE = 8'h00;
    localparam logic [7:0]  REGION_ISE  = 8'h01;
    localparam logic [31:0] CODE_BASE   = 32'h0000_3000;
    localparam logic [31:0] ISE_BASE    = 32'h0000_4180;

    // Loader FSM encoding, fixed at 3 bits so region-select logic can decode it.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REGION = 3'd1,
        ST_LEN_HI = 3'd2,
        ST_LEN_LO = 3'd3,
        ST_DATA   = 3'd4,
        ST_CSUM   = 3'd5,
        ST_DONE   = 3'd6,
        ST_ERR    = 3'd7
    } loader_state_t;

    // True when the region id names a known region.
    function automatic logic region_ok(input logic [7:0] id);
        return (id == REGION_CODE) || (id == REGION_ISE);
    endfunction

    // Word base address of a region (only meaningful when region_ok).
    function automatic logic [WADDR_W-1:0] region_wbase(input logic [7:0] id);
        return (id == REGION_ISE) ? ISE_BASE[31:2] : CODE_BASE[31:2];
    endfunction

endpackage

// File: rtl/im_word_assembler.sv
// Shifts big-endian bytes into a 32-bit word and flags the 4th byte of each word.
module im_word_assembler
    import im_boot_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              push,
    input  logic [7:0]        byte_in,
    output logic [31:0]       word_c,
    output logic              word_done_c
);

    logic [23:0] shreg;
    logic [1:0]  count;

    // Word completes combinationally with the incoming 4th byte.
    assign word_c      = {shreg, byte_in};
    assign word_done_c = push && (count == 2'd3);

    // Byte shift register and position counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg <= '0;
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (push) begin
            shreg <= {shreg[15:0], byte_in};
            count <= count + 2'd1;
        end
    end

endmodule

// File: rtl/im_boot_loader.sv
// Receives a framed program image over UART bytes and writes it into instruction memory.
module im_boot_loader
    import im_boot_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        im_we,
    output logic [29:0] im_waddr,
    output logic [31:0] im_wdata,
    output logic        cpu_hold,
    output logic        load_done,
    output logic        load_err
);

    loader_state_t       state, state_d;
    logic [7:0]          csum, csum_d;
    logic [WADDR_W-1:0]  wbase, wbase_d;
    logic [7:0]          len_hi, len_hi_d;
    logic [LEN_W-1:0]    len, len_d;
    logic [WIDX_W-1:0]   widx, widx_d;
    logic                we_d, hold_d, done_d, err_d;
    logic [29:0]         waddr_d;
    logic [31:0]         wdata_d;
    logic                asm_clear_c, asm_push_c;
    logic [31:0]         asm_word_c;
    logic                asm_done_c;
    logic [15:0]         n_c;

    im_word_assembler u_asm (
        .clk         (clk),
        .rst         (rst),
        .clear       (asm_clear_c),
        .push        (asm_push_c),
        .byte_in     (rx_data),
        .word_c      (asm_word_c),
        .word_done_c (asm_done_c)
    );

    assign n_c = {len_hi, rx_data};

    // Next-state and next-output logic; every transition is gated by rx_valid.
    always_comb begin
        state_d     = state;
        csum_d      = csum;
        wbase_d     = wbase;
        len_hi_d    = len_hi;
        len_d       = len;
        widx_d      = widx;
        we_d        = 1'b0;
        waddr_d     = im_waddr;
        wdata_d     = im_wdata;
        hold_d      = cpu_hold;
        done_d      = load_done;
        err_d       = load_err;
        asm_clear_c = 1'b0;
        asm_push_c  = 1'b0;

        if (rx_valid) begin
            unique case (state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (rx_data == SYNC_BYTE) begin
                        state_d     = ST_REGION;
                        hold_d      = 1'b1;
                        done_d      = 1'b0;
                        err_d       = 1'b0;
                        csum_d      = '0;
                        asm_clear_c = 1'b1;
                    end
                end
                ST_REGION: begin
                    csum_d  = csum ^ rx_data;
                    wbase_d = region_wbase(rx_data);
                    if (region_ok(rx_data)) begin
                        state_d = ST_LEN_HI;
                    end else begin
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                    end
                end
                ST_LEN_HI: begin
                    csum_d   = csum ^ rx_data;
                    len_hi_d = rx_data;
                    state_d  = ST_LEN_LO;
                end
                ST_LEN_LO: begin
                    csum_d = csum ^ rx_data;
                    len_d  = n_c[LEN_W-1:0];
                    widx_d = '0;
                    if (n_c > 16'(DEPTH_WORDS)) begin
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                    end else if (n_c == 16'd0) begin
                        state_d = ST_CSUM;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
                ST_DATA: begin
                    csum_d     = csum ^ rx_data;
                    asm_push_c = 1'b1;
                    if (asm_done_c) begin
                        we_d    = 1'b1;
                        waddr_d = wbase + WADDR_W'(widx);
                        wdata_d = asm_word_c;
                        widx_d  = widx + WIDX_W'(1);
                        if ((LEN_W'(widx) + LEN_W'(1)) == len) begin
                            state_d = ST_CSUM;
                        end
                    end
                end
                ST_CSUM: begin
                    if (rx_data == csum) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
                    end else begin
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                        hold_d  = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            csum      <= '0;
            wbase     <= '0;
            len_hi    <= '0;
            len       <= '0;
            widx      <= '0;
            im_we     <= 1'b0;
            im_waddr  <= '0;
            im_wdata  <= '0;
            cpu_hold  <= 1'b1;
            load_done <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            state     <= state_d;
            csum      <= csum_d;
            wbase     <= wbase_d;
            len_hi    <= len_hi_d;
            len       <= len_d;
            widx      <= widx_d;
            im_we     <= we_d;
            im_waddr  <= waddr_d;
            im_wdata  <= wdata_d;
            cpu_hold  <= hold_d;
            load_done <= done_d;
            load_err  <= err_d;
        end
    end

endmodule

// File: tb/tb_im_boot_loader.sv
// Directed bench for im_boot_loader: frames in, memory writes and status flags checked.
module tb_im_boot_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        im_we;
    logic [29:0] im_waddr;
    logic [31:0] im_wdata;
    logic        cpu_hold;
    logic        load_done;
    logic        load_err;

    int tests = 0;
    int fails = 0;

    logic [7:0]  fq[$];
    logic [29:0] wa_q[$];
    logic [31:0] wd_q[$];
    logic        prev_we = 1'b0;

    im_boot_loader dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .im_we     (im_we),
        .im_waddr  (im_waddr),
        .im_wdata  (im_wdata),
        .cpu_hold  (cpu_hold),
        .load_done (load_done),
        .load_err  (load_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Record every write; a write strobe must never follow another.
    always @(negedge clk) begin
        if (im_we) begin
            check("we_single", 32'(prev_we), 32'd0);
            wa_q.push_back(im_waddr);
            wd_q.push_back(im_wdata);
        end
        prev_we = im_we;
    end

    function automatic logic [7:0] csum_of();
        logic [7:0] c = 8'h00;
        for (int i = 1; i < fq.size(); i++) c ^= fq[i];
        return c;
    endfunction

    task automatic send_byte(input logic [7:0] b, output logic we);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        we       = im_we;
        rx_valid = 1'b0;
    endtask

    // Sends fq; expects a write strobe right after the 4th byte of each of the first exp_words words.
    task automatic send_frame(input int exp_words);
        logic we;
        logic exp;
        for (int p = 0; p < fq.size(); p++) begin
            send_byte(fq[p], we);
            exp = (p >= 4) && (((p - 4) / 4) < exp_words) && (((p - 4) % 4) == 3);
            check("we_latency", 32'(we), 32'(exp));
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_flags(input string tag, input logic done, input logic err, input logic hold);
        check({tag, "_done"}, 32'(load_done), 32'(done));
        check({tag, "_err"},  32'(load_err),  32'(err));
        check({tag, "_hold"}, 32'(cpu_hold),  32'(hold));
    endtask

    initial begin
        int  base;
        logic we;
        rst      = 1'b1;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        do_reset();

        // Reset state.
        check("rst_we",    32'(im_we), 32'd0);
        check("rst_waddr", 32'(im_waddr), 32'd0);
        check("rst_wdata", im_wdata, 32'd0);
        check_flags("rst", 1'b0, 1'b0, 1'b1);

        // Good code frame, two words, garbage bytes ignored first.
        send_byte(8'h11, we);
        send_byte(8'h00, we);
        base = wa_q.size();
        fq = {8'hA5, 8'h00, 8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78,
              8'h9A, 8'hBC, 8'hDE, 8'hF0};
        fq.push_back(csum_of());
        check("code_csum_val", 32'(fq[fq.size()-1]), 32'h02);
        send_frame(2);
        check("code_nwr", 32'(wa_q.size() - base), 32'd2);
        if (wa_q.size() - base == 2) begin
            check("code_a0", 32'(wa_q[base]),   32'h0000_0C00);
            check("code_d0", wd_q[base],        32'h1234_5678);
            check("code_a1", 32'(wa_q[base+1]), 32'h0000_0C01);
            check("code_d1", wd_q[base+1],      32'h9ABC_DEF0);
        end
        check_flags("code", 1'b1, 1'b0, 1'b0);
        check("hold_addr", 32'(im_waddr), 32'h0000_0C01);
        check("hold_data", im_wdata, 32'h9ABC_DEF0);

        // Exception-handler region frame.
        base = wa_q.size();
        fq = {8'hA5, 8'h01, 8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};
        send_frame(1);
        check("ise_nwr", 32'(wa_q.size() - base), 32'd1);
        if (wa_q.size() - base == 1) begin
            check("ise_a0", 32'(wa_q[base]), 32'h0000_1060);
            check("ise_d0", wd_q[base],      32'hDEAD_BEEF);
        end
        check_flags("ise", 1'b1, 1'b0, 1'b0);

        // Bad checksum: the write still happens, frame rejected.
        base = wa_q.size();
        fq = {8'hA5, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'hFF};
        send_frame(1);
        check("badcs_nwr", 32'(wa_q.size() - base), 32'd1);
        if (wa_q.size() - base == 1) check("badcs_d0", wd_q[base], 32'h0000_0001);
        check_flags("badcs", 1'b0, 1'b1, 1'b1);

        // Bad region id.
        base = wa_q.size();
        fq = {8'hA5, 8'h02, 8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00};
        send_frame(0);
        check("badreg_nwr", 32'(wa_q.size() - base), 32'd0);
        check_flags("badreg", 1'b0, 1'b1, 1'b1);

        // Length one past the region depth.
        base = wa_q.size();
        fq = {8'hA5, 8'h00, 8'h04, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
        send_frame(0);
        check("badlen_nwr", 32'(wa_q.size() - base), 32'd0);
        check_flags("badlen", 1'b0, 1'b1, 1'b1);

        // Zero length frame.
        base = wa_q.size();
        fq = {8'hA5, 8'h00, 8'h00, 8'h00, 8'h00};
        send_frame(0);
        check("zero_nwr", 32'(wa_q.size() - base), 32'd0);
        check_flags("zero", 1'b1, 1'b0, 1'b0);

        // SYNC value inside the data is plain data.
        base = wa_q.size();
        fq = {8'hA5, 8'h00, 8'h00, 8'h01, 8'hA5, 8'hA5, 8'hA5, 8'hA5};
        fq.push_back(csum_of());
        send_frame(1);
        check("syncdat_nwr", 32'(wa_q.size() - base), 32'd1);
        if (wa_q.size() - base == 1) begin
            check("syncdat_a0", 32'(wa_q[base]), 32'h0000_0C00);
            check("syncdat_d0", wd_q[base],      32'hA5A5_A5A5);
        end
        check_flags("syncdat", 1'b1, 1'b0, 1'b0);

        // Reset mid-DATA, then a full good frame.
        base = wa_q.size();
        fq = {8'hA5, 8'h00, 8'h00, 8'h02, 8'h55, 8'h66};
        for (int p = 0; p < fq.size(); p++) send_byte(fq[p], we);
        check("mid_hold_pre", 32'(cpu_hold), 32'd1);
        do_reset();
        check_flags("midrst", 1'b0, 1'b0, 1'b1);
        fq = {8'hA5, 8'h00, 8'h00, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04,
              8'h05, 8'h06, 8'h07, 8'h08};
        fq.push_back(csum_of());
        send_frame(2);
        check("mid_nwr", 32'(wa_q.size() - base), 32'd2);
        if (wa_q.size() - base == 2) begin
            check("mid_a0", 32'(wa_q[base]),   32'h0000_0C00);
            check("mid_d0", wd_q[base],        32'h0102_0304);
            check("mid_a1", 32'(wa_q[base+1]), 32'h0000_0C01);
            check("mid_d1", wd_q[base+1],      32'h0506_0708);
        end
        check_flags("mid", 1'b1, 1'b0, 1'b0);

        // Maximum length frame fills the region exactly.
        base = wa_q.size();
        fq = {8'hA5, 8'h00, 8'h04, 8'h00};
        for (int i = 0; i < 4096; i++) fq.push_back(8'(i));
        fq.push_back(csum_of());
        send_frame(1024);
        check("max_nwr", 32'(wa_q.size() - base), 32'd1024);
        if (wa_q.size() - base == 1024) begin
            for (int k = 0; k < 1024; k++) begin
                check("max_addr", 32'(wa_q[base+k]), 32'h0000_0C00 + 32'(k));
                check("max_data", wd_q[base+k],
                      {8'(4*k), 8'(4*k+1), 8'(4*k+2), 8'(4*k+3)});
            end
        end
        check_flags("max", 1'b1, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
